// File: rtl/ibex_scramble_resp_pkg.sv
// rtl/ibex_scramble_resp_pkg.sv - shared widths, FSM states and LFSR step for the scramble-key responder
package ibex_scramble_resp_pkg;

  localparam int KEY_W   = 128;
  localparam int NONCE_W = 64;

  // Galois feedback mask for taps 64,63,61,60 on a right-shifting register
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GEN       = 2'd1,
    ST_RESP      = 2'd2,
    ST_WAIT_DROP = 2'd3
  } scramble_state_e;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    lfsr_next = {1'b0, s[63:1]} ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/ibex_scramble_lfsr64.sv
// rtl/ibex_scramble_lfsr64.sv - 64-bit Galois LFSR key source, built only with SCRAMBLE_RESP_LFSR_EN
`ifdef SCRAMBLE_RESP_LFSR_EN
module ibex_scramble_lfsr64
  import ibex_scramble_resp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] seed_i,
  input  logic        en_i,
  output logic [63:0] state_o
);

  logic [63:0] lfsr_d;
  logic [63:0] lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= seed_i;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule
`endif

// File: rtl/ibex_scramble_key_responder.sv
// rtl/ibex_scramble_key_responder.sv - answers scramble_req with a key/nonce pulse; SCRAMBLE_RESP_LFSR_EN selects LFSR-derived keys
module ibex_scramble_key_responder
  import ibex_scramble_resp_pkg::*;
#(
  parameter int unsigned LATENCY  = 4,
  parameter logic [63:0] KEY_SEED = 64'h0123_4567_89AB_CDEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               scramble_req_i,
  output logic               scramble_key_valid_o,
  output logic [KEY_W-1:0]   scramble_key_o,
  output logic [NONCE_W-1:0] scramble_nonce_o,
  output logic               busy_o,
  output logic [7:0]         req_count_o,
  output logic               proto_err_o
);

  localparam logic [1:0] S_IDLE      = ST_IDLE;
  localparam logic [1:0] S_GEN       = ST_GEN;
  localparam logic [1:0] S_RESP      = ST_RESP;
  localparam logic [1:0] S_WAIT_DROP = ST_WAIT_DROP;
  localparam logic [3:0] CNT_INIT    = 4'(LATENCY - 1);

  logic [1:0]         state_d, state_q;
  logic [3:0]         cnt_d, cnt_q;
  logic [KEY_W-1:0]   key_d, key_q;
  logic [NONCE_W-1:0] nonce_d, nonce_q;
  logic [7:0]         req_count_d, req_count_q;
  logic               proto_err_d, proto_err_q;
  logic               gen_step;

`ifdef SCRAMBLE_RESP_LFSR_EN
  // A zero seed would lock the LFSR at zero forever
  localparam logic [63:0] SEED_EFF = (KEY_SEED == 64'h0) ? 64'h1 : KEY_SEED;
  logic [63:0] lfsr_q;

  ibex_scramble_lfsr64 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .seed_i  (SEED_EFF),
    .en_i    (gen_step),
    .state_o (lfsr_q)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_count_d = req_count_q;
    proto_err_d = proto_err_q;
    gen_step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scramble_req_i) begin
          state_d = S_GEN;
          cnt_d   = CNT_INIT;
        end
      end
      S_GEN: begin
        if (!scramble_req_i) begin
          state_d     = S_IDLE;
          proto_err_d = 1'b1;
        end else begin
          gen_step = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_RESP: begin
        req_count_d = req_count_q + 8'd1;
        state_d     = scramble_req_i ? S_WAIT_DROP : S_IDLE;
      end
      S_WAIT_DROP: begin
        if (!scramble_req_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    key_d   = key_q;
    nonce_d = nonce_q;
`ifdef SCRAMBLE_RESP_LFSR_EN
    if (gen_step) begin
      key_d   = {key_q[63:0], lfsr_q};
      nonce_d = lfsr_q ^ key_q[127:64];
    end
`else
    // Fixed pattern loaded on the last GEN cycle; req_count_q is still the pre-delivery count
    if (gen_step && cnt_q == 4'd0) begin
      key_d   = {KEY_SEED, ~KEY_SEED};
      nonce_d = KEY_SEED ^ {56'b0, req_count_q};
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      key_q       <= '0;
      nonce_q     <= '0;
      req_count_q <= 8'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      req_count_q <= req_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign scramble_key_valid_o = (state_q == S_RESP);
  assign scramble_key_o       = scramble_key_valid_o ? key_q : '0;
  assign scramble_nonce_o     = scramble_key_valid_o ? nonce_q : '0;
  assign busy_o               = (state_q == S_GEN) || (state_q == S_RESP);
  assign req_count_o          = req_count_q;
  assign proto_err_o          = proto_err_q;

endmodule

// File: tb/tb_ibex_scramble_key_responder.sv
// tb/tb_ibex_scramble_key_responder.sv - scoreboard bench for the scramble-key responder
module tb_ibex_scramble_key_responder;

  localparam int          LAT  = 4;
  localparam int          LAT2 = 2;
  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SEED_EFF = SEED;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, req, req2;
  logic         valid, busy, perr, valid2, busy2, perr2;
  logic [127:0] key, key2;
  logic [63:0]  nonce, nonce2;
  logic [7:0]   cnt, cnt2;

  ibex_scramble_key_responder #(.LATENCY(LAT), .KEY_SEED(SEED)) dut (
    .clk_i(clk), .rst_i(rst_i), .scramble_req_i(req),
    .scramble_key_valid_o(valid), .scramble_key_o(key), .scramble_nonce_o(nonce),
    .busy_o(busy), .req_count_o(cnt), .proto_err_o(perr)
  );

  ibex_scramble_key_responder #(.LATENCY(LAT2), .KEY_SEED(64'h0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .scramble_req_i(req2),
    .scramble_key_valid_o(valid2), .scramble_key_o(key2), .scramble_nonce_o(nonce2),
    .busy_o(busy2), .req_count_o(cnt2), .proto_err_o(perr2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [127:0] key;
    logic [63:0]  nonce;
    logic [7:0]   cnt_after;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] m_lfsr;
  logic [63:0] m_hist[$];
  int          m_count;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Galois step written from the tap list 64,63,61,60
  function automatic logic [63:0] ref_step(input logic [63:0] s);
    logic [63:0] fb;
    fb = (64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59);
    return s[0] ? ((s >> 1) ^ fb) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_lfsr  = SEED_EFF;
    m_hist  = {64'h0, 64'h0};
    m_count = 0;
    sb_q.delete();
  endtask

  // Each effective GEN cycle consumes one LFSR word into the key history
  task automatic model_gen(input int n);
    repeat (n) begin
      m_hist.push_back(m_lfsr);
      m_lfsr = ref_step(m_lfsr);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
    end
  endtask

  task automatic model_deliver();
    exp_t e;
    int   h;
    h = m_hist.size();
`ifdef SCRAMBLE_RESP_LFSR_EN
    e.key   = {m_hist[h-2], m_hist[h-1]};
    e.nonce = m_hist[h-1] ^ m_hist[h-3];
`else
    e.key   = {SEED, ~SEED};
    e.nonce = SEED ^ 64'(m_count);
    if (h < 0) e.key = '0;
`endif
    m_count     = (m_count + 1) % 256;
    e.cnt_after = 8'(m_count);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic full_req(input int extra, input int gap);
    model_gen(LAT);
    model_deliver();
    req = 1'b1;
    repeat (LAT + 1 + extra) tick();
    req = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic abort_req(input int j, input int gap);
    model_gen(j - 1);
    req = 1'b1;
    repeat (j) tick();
    req = 1'b0;
    tick();
    @(negedge clk);
    check("abort_proto_err", perr, 1'b1);
    check("abort_idle", busy, 1'b0);
    repeat (gap - 1) tick();
    if (gap <= 1) tick();
  endtask

  task automatic directed_full();
    model_gen(LAT);
    model_deliver();
    req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", c), busy, (c >= 1 && c <= 5));
      check($sformatf("valid_c%0d", c), valid, (c == 5));
      tick();
    end
    req = 1'b0;
    tick();
  endtask

  // Monitor: pops an expectation on every valid pulse, checks gating otherwise
  exp_t         mon_e;
  bit           pend = 1'b0;
  logic [7:0]   pend_cnt;
  bit           have_last = 1'b0;
  logic [127:0] last_key;

  always @(negedge clk) begin
    if (pend) begin
      check("req_count_after_valid", cnt, pend_cnt);
      pend = 1'b0;
    end
    if (valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", valid, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check("key", key, mon_e.key);
        check("nonce", nonce, mon_e.nonce);
        pend     = 1'b1;
        pend_cnt = mon_e.cnt_after;
`ifdef SCRAMBLE_RESP_LFSR_EN
        if (have_last) begin
          n_tests++;
          if (key == last_key) begin
            n_fail++;
            $display("FAIL key_changes: got %h expected a different key", key);
          end
        end
`endif
        have_last = 1'b1;
        last_key  = key;
      end
    end else begin
      check("key_gated", key, '0);
      check("nonce_gated", {64'h0, nonce}, '0);
    end
  end

  logic [127:0] exp_key2;
  logic [63:0]  exp_nonce2;

  initial begin
    rst_i = 1'b1;
    req   = 1'b0;
    req2  = 1'b0;
    model_reset();
    repeat (2) tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", cnt, 8'd0);
    check("rst_perr", perr, 1'b0);
    tick();

    // Held request: valid at cycle LAT+1, count visible a cycle later via the monitor
    directed_full();

    // Request dropped at cycle 2 while generating
    model_gen(1);
    req = 1'b1;
    repeat (2) tick();
    req = 1'b0;
    tick();
    for (int c = 3; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("perr_c%0d", c), perr, 1'b1);
      check($sformatf("abort_novalid_c%0d", c), valid, 1'b0);
      check($sformatf("abort_idle_c%0d", c), busy, 1'b0);
      tick();
    end
    directed_full();

    // Reset during GEN cycle 2
    req = 1'b1;
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req   = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_valid", valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", cnt, 8'd0);
    check("midrst_perr", perr, 1'b0);
    tick();
    directed_full();

    // Zero-seed instance with LATENCY 2
`ifdef SCRAMBLE_RESP_LFSR_EN
    exp_key2   = {64'h1, ref_step(64'h1)};
    exp_nonce2 = ref_step(64'h1);
`else
    exp_key2   = {64'h0, ~64'h0};
    exp_nonce2 = 64'h0;
`endif
    req2 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("seed0_valid_c%0d", c), valid2, (c == LAT2 + 1));
      if (c == LAT2 + 1) begin
        check("seed0_key", key2, exp_key2);
        check("seed0_nonce", nonce2, exp_nonce2);
        n_tests++;
        if (key2 == '0) begin
          n_fail++;
          $display("FAIL seed0_key_nonzero: got %h expected nonzero", key2);
        end
        req2 = 1'b0;
      end
      tick();
    end

    // Random mix of full handshakes and aborts, enough to wrap req_count
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        abort_req($urandom_range(1, LAT), $urandom_range(1, 3));
      end else begin
        full_req($urandom_range(0, 3), $urandom_range(1, 3));
      end
    end
    repeat (LAT + 3) tick();
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("final_count", cnt, 8'(m_count));
    check("final_perr", perr, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
